// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg: register word indices and bus width shared by the
// MMIO switch/LED controller and its testbench.
package mmio_io_pkg;
   localparam int unsigned BUS_W    = 32;
   localparam int unsigned SW_IDX   = 0;
   localparam int unsigned LED_IDX  = 1;
   localparam int unsigned EDGE_IDX = 2;
   localparam int unsigned MASK_IDX = 3;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-FF synchroniser, shared sample tick and per-bit
// DEB_N-deep history that accepts a level once all samples agree.
module io_debounce
   import mmio_io_pkg::*;
#(
   parameter int IO_W    = 24,
   parameter int DEB_DIV = 1000,
   parameter int DEB_N   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IO_W-1:0] raw,
   output logic [IO_W-1:0] level,
   output logic [IO_W-1:0] rise
);
   localparam int CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

   logic [IO_W-1:0]            r_s1;
   logic [IO_W-1:0]            r_s2;
   logic [IO_W-1:0]            r_level;
   logic [CW-1:0]              r_cnt;
   logic [IO_W-1:0][DEB_N-1:0] r_hist;
   logic [IO_W-1:0][DEB_N-1:0] w_hist;
   logic [IO_W-1:0]            w_set;
   logic [IO_W-1:0]            w_clr;
   logic                       w_tick;

   assign w_tick = (r_cnt == CW'(DEB_DIV - 1));

   // Decision uses the history including the sample taken this tick
   always_comb begin
      w_hist = r_hist;
      w_set  = '0;
      w_clr  = '0;
      for (int i = 0; i < IO_W; i++) begin
         w_hist[i] = {r_hist[i][DEB_N-2:0], r_s2[i]};
         w_set[i]  = w_tick & (&w_hist[i]) & ~r_level[i];
         w_clr[i]  = w_tick & ~(|w_hist[i]) & r_level[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_cnt   <= '0;
         r_hist  <= '0;
         r_level <= '0;
      end else begin
         r_s1    <= raw;
         r_s2    <= r_s1;
         r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) r_hist <= w_hist;
         r_level <= (r_level | w_set) & ~w_clr;
      end
   end

   assign level = r_level;
   assign rise  = w_set;
endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: bus-mapped switches (SW, EDGE W1C) and LEDs.
// Define MMIO_IO_IRQ_EN to add the MASK register and irq output.
module mmio_io_ctrl
   import mmio_io_pkg::*;
#(
   parameter int IO_W    = 24,
   parameter int DEB_DIV = 1000,
   parameter int DEB_N   = 4,
   parameter int ADDR_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BUS_W-1:0]  wdata,
   output logic [BUS_W-1:0]  rdata,
   output logic              ready,
   input  logic [IO_W-1:0]   io_rdata,
   output logic [IO_W-1:0]   io_wdata,
   output logic              irq
);
   logic             r_ready;
   logic [BUS_W-1:0] r_rdata;
   logic [IO_W-1:0]  r_led;
   logic [IO_W-1:0]  r_edge;
   logic [IO_W-1:0]  w_sw;
   logic [IO_W-1:0]  w_rise;
   logic [IO_W-1:0]  w_wd;
   logic [IO_W-1:0]  w_clr;
   logic [IO_W-1:0]  w_rsel;
   logic [BUS_W-1:0] w_rd;
   logic             w_rd_en;
   logic             w_wr_led;
   logic             w_wr_edge;
   logic             w_unused;

   io_debounce #(
      .IO_W    (IO_W),
      .DEB_DIV (DEB_DIV),
      .DEB_N   (DEB_N)
   ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (io_rdata),
      .level (w_sw),
      .rise  (w_rise)
   );

   assign w_wd      = wdata[IO_W-1:0];
   assign w_unused  = ^wdata;
   assign w_rd_en   = req & ~wr;
   assign w_wr_led  = req & wr & (addr == ADDR_W'(LED_IDX));
   assign w_wr_edge = req & wr & (addr == ADDR_W'(EDGE_IDX));
   assign w_clr     = w_wr_edge ? w_wd : '0;

`ifdef MMIO_IO_IRQ_EN
   logic [IO_W-1:0] r_mask;
   logic            r_irq;
   logic            w_wr_mask;

   assign w_wr_mask = req & wr & (addr == ADDR_W'(MASK_IDX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         if (w_wr_mask) r_mask <= w_wd;
         r_irq <= |(r_edge & r_mask);
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      w_rsel = '0;
      case (addr)
         ADDR_W'(SW_IDX):   w_rsel = w_sw;
         ADDR_W'(LED_IDX):  w_rsel = r_led;
         ADDR_W'(EDGE_IDX): w_rsel = r_edge;
`ifdef MMIO_IO_IRQ_EN
         ADDR_W'(MASK_IDX): w_rsel = r_mask;
`endif
         default:           w_rsel = '0;
      endcase
      w_rd = '0;
      w_rd[IO_W-1:0] = w_rsel;
   end

   // A new rise wins over a same-cycle W1C of that bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready <= 1'b0;
         r_rdata <= '0;
         r_led   <= '0;
         r_edge  <= '0;
      end else begin
         r_ready <= req;
         r_rdata <= w_rd_en ? w_rd : '0;
         if (w_wr_led) r_led <= w_wd;
         r_edge <= (r_edge & ~w_clr) | w_rise;
      end
   end

   assign ready    = r_ready;
   assign rdata    = r_rdata;
   assign io_wdata = r_led;
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed vectors plus a sample-based reference
// model of the switch/LED controller compared every clock.
module tb_mmio_io_ctrl;
   localparam int IO_W    = 24;
   localparam int DEB_DIV = 4;
   localparam int DEB_N   = 4;
   localparam int ADDR_W  = 3;
`ifdef MMIO_IO_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req = 1'b0;
   logic              wr = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [31:0]       wdata = '0;
   logic [31:0]       rdata;
   logic              ready;
   logic [IO_W-1:0]   io_rdata = 24'hFFFFFF;
   logic [IO_W-1:0]   io_wdata;
   logic              irq;

   int n_tests = 0;
   int n_fail  = 0;

   mmio_io_ctrl #(
      .IO_W    (IO_W),
      .DEB_DIV (DEB_DIV),
      .DEB_N   (DEB_N),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .io_rdata (io_rdata),
      .io_wdata (io_wdata),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Reference model: raw input seen two clocks late, sampled every
   // DEB_DIV clocks; a level is accepted once DEB_N samples agree.
   logic [IO_W-1:0] raw_q[$];
   logic [IO_W-1:0] samp_q[$];
   int              m_cnt;
   logic            m_ready;
   logic            m_irq;
   logic [31:0]     m_rdata;
   logic [IO_W-1:0] m_sw;
   logic [IO_W-1:0] m_led;
   logic [IO_W-1:0] m_edge;
   logic [IO_W-1:0] m_mask;

   task automatic m_reset();
      raw_q = {};
      samp_q = {};
      repeat (2) raw_q.push_back('0);
      repeat (DEB_N) samp_q.push_back('0);
      m_cnt = 0;
      m_ready = 1'b0;
      m_irq = 1'b0;
      m_rdata = '0;
      m_sw = '0;
      m_led = '0;
      m_edge = '0;
      m_mask = '0;
   endtask

   task automatic m_step();
      logic [IO_W-1:0] syn, nsw, rise, clr, rd;
      bit all1, all0;
      syn = raw_q.pop_front();
      raw_q.push_back(io_rdata);
      nsw = m_sw;
      rise = '0;
      if (m_cnt == DEB_DIV - 1) begin
         samp_q.push_back(syn);
         void'(samp_q.pop_front());
         for (int b = 0; b < IO_W; b++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            foreach (samp_q[k]) begin
               if (samp_q[k][b]) all0 = 1'b0;
               else all1 = 1'b0;
            end
            if (all1 && !m_sw[b]) begin
               nsw[b] = 1'b1;
               rise[b] = 1'b1;
            end
            if (all0) nsw[b] = 1'b0;
         end
      end
      m_cnt = (m_cnt + 1) % DEB_DIV;
      rd = '0;
      clr = '0;
      if (req && !wr) begin
         case (addr)
            3'd0: rd = m_sw;
            3'd1: rd = m_led;
            3'd2: rd = m_edge;
            3'd3: rd = IRQ_ON ? m_mask : '0;
            default: rd = '0;
         endcase
      end
      m_irq = IRQ_ON && ((m_edge & m_mask) != 0);
      if (req && wr) begin
         case (addr)
            3'd1: m_led = wdata[IO_W-1:0];
            3'd2: clr = wdata[IO_W-1:0];
            3'd3: m_mask = IRQ_ON ? wdata[IO_W-1:0] : '0;
            default: ;
         endcase
      end
      m_ready = req;
      m_rdata = {8'h0, rd};
      m_edge = (m_edge & ~clr) | rise;
      m_sw = nsw;
   endtask

   initial m_reset();

   always @(posedge clk or negedge rst) begin
      if (!rst) m_reset();
      else m_step();
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         chk("ready", {31'b0, ready}, {31'b0, m_ready});
         chk("rdata", rdata, m_rdata);
         chk("io_wdata", {8'h0, io_wdata}, {8'h0, m_led});
         chk("irq", {31'b0, irq}, {31'b0, m_irq});
      end
   end

   task automatic access(input logic w, input logic [2:0] a,
                         input logic [31:0] d,
                         output logic [31:0] rd, output logic rdy);
      @(negedge clk);
      req = 1'b1;
      wr = w;
      addr = a;
      wdata = d;
      @(negedge clk);
      req = 1'b0;
      wr = 1'b0;
      rd = rdata;
      rdy = ready;
   endtask

   initial begin
      logic [31:0] rd;
      logic        rdy;
      int          k;

      // Reset with all switches high
      repeat (20) @(negedge clk);
      chk("rst_io_wdata", {8'h0, io_wdata}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ready", {31'b0, ready}, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      rst = 1'b1;
      repeat (7) @(negedge clk);
      access(1'b0, 3'd0, 32'h0, rd, rdy);
      chk("sw_early", rd, 32'h0);
      repeat (12) @(negedge clk);
      access(1'b0, 3'd0, 32'h0, rd, rdy);
      chk("sw_settled", rd, 32'h00FFFFFF);
      access(1'b0, 3'd2, 32'h0, rd, rdy);
      chk("edge_all", rd, 32'h00FFFFFF);

      // LED path and back-to-back accesses
      access(1'b1, 3'd1, 32'h00A5A5A5, rd, rdy);
      chk("led_wr_ready", {31'b0, rdy}, 32'h1);
      chk("led_out", {8'h0, io_wdata}, 32'h00A5A5A5);
      access(1'b0, 3'd1, 32'h0, rd, rdy);
      chk("led_rd", rd, 32'h00A5A5A5);
      @(negedge clk);
      req = 1'b1;
      wr = 1'b1;
      addr = 3'd1;
      wdata = 32'h00123456;
      @(negedge clk);
      chk("b2b_wr_ready", {31'b0, ready}, 32'h1);
      wr = 1'b0;
      @(negedge clk);
      chk("b2b_rd_ready", {31'b0, ready}, 32'h1);
      chk("b2b_rd_data", rdata, 32'h00123456);
      req = 1'b0;

      // Debounce: short pulse rejected, long level accepted
      io_rdata = '0;
      repeat (30) @(negedge clk);
      access(1'b1, 3'd2, 32'h00FFFFFF, rd, rdy);
      access(1'b0, 3'd0, 32'h0, rd, rdy);
      chk("sw_low", rd, 32'h0);
      io_rdata = 24'h000001;
      repeat (8) @(negedge clk);
      io_rdata = '0;
      repeat (30) @(negedge clk);
      access(1'b0, 3'd0, 32'h0, rd, rdy);
      chk("glitch_sw", rd, 32'h0);
      access(1'b0, 3'd2, 32'h0, rd, rdy);
      chk("glitch_edge", rd, 32'h0);
      io_rdata = 24'h000001;
      repeat (19) @(negedge clk);
      access(1'b0, 3'd0, 32'h0, rd, rdy);
      chk("deb_sw", rd, 32'h1);
      access(1'b0, 3'd2, 32'h0, rd, rdy);
      chk("deb_edge", rd, 32'h1);

      // W1C, then W1C colliding with a fresh rise
      io_rdata = 24'h000009;
      repeat (25) @(negedge clk);
      access(1'b0, 3'd2, 32'h0, rd, rdy);
      chk("edge_9", rd, 32'h9);
      access(1'b1, 3'd2, 32'h1, rd, rdy);
      access(1'b0, 3'd2, 32'h0, rd, rdy);
      chk("w1c_bit0", rd, 32'h8);
      io_rdata = 24'h000001;
      repeat (25) @(negedge clk);
      io_rdata = 24'h000009;
      k = 2;
      while ((m_cnt + k) % DEB_DIV != DEB_DIV - 1) k++;
      k += (DEB_N - 1) * DEB_DIV;
      repeat (k - 1) @(negedge clk);
      access(1'b1, 3'd2, 32'h8, rd, rdy);
      access(1'b0, 3'd2, 32'h0, rd, rdy);
      chk("set_wins", rd, 32'h8);

      // Interrupt mask and level
      access(1'b1, 3'd2, 32'h00FFFFFF, rd, rdy);
      access(1'b1, 3'd3, 32'h8, rd, rdy);
      io_rdata = 24'h000001;
      repeat (25) @(negedge clk);
      io_rdata = 24'h000009;
      repeat (25) @(negedge clk);
      chk("irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
      access(1'b0, 3'd3, 32'h0, rd, rdy);
      chk("mask_rd", rd, IRQ_ON ? 32'h8 : 32'h0);
      access(1'b1, 3'd2, 32'h8, rd, rdy);
      @(negedge clk);
      chk("irq_clr", {31'b0, irq}, 32'h0);

      // Unmapped index and async reset mid-access
      access(1'b0, 3'd5, 32'h0, rd, rdy);
      chk("unmap_rd", rd, 32'h0);
      chk("unmap_ready", {31'b0, rdy}, 32'h1);
      access(1'b1, 3'd5, 32'hFFFFFFFF, rd, rdy);
      access(1'b0, 3'd1, 32'h0, rd, rdy);
      chk("unmap_led", rd, 32'h00123456);
      access(1'b0, 3'd2, 32'h0, rd, rdy);
      chk("unmap_edge", rd, 32'h0);
      access(1'b0, 3'd0, 32'h0, rd, rdy);
      chk("unmap_sw", rd, 32'h9);
      access(1'b0, 3'd3, 32'h0, rd, rdy);
      chk("unmap_mask", rd, IRQ_ON ? 32'h8 : 32'h0);
      @(negedge clk);
      req = 1'b1;
      addr = 3'd1;
      @(posedge clk);
      #1;
      chk("pend_ready", {31'b0, ready}, 32'h1);
      req = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ready", {31'b0, ready}, 32'h0);
      chk("arst_rdata", rdata, 32'h0);
      chk("arst_led", {8'h0, io_wdata}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the CPU data bus and board switches/LEDs; successor to the fixed 24-bit io_rdata/io_wdata hookup.
- Adds configurable width, 2-FF input synchroniser, per-bit debounce, rising-edge capture with write-1-to-clear, and a single-cycle request/ready handshake.

Parameters:
- IO_W, 24, switch and LED width in bits (1..32).
- DEB_DIV, 1000, clk cycles per debounce sample tick (>=1).
- DEB_N, 4, consecutive equal samples needed to accept a new switch level (2..8).
- ADDR_W, 3, word-address width of the register window.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  one-cycle bus access strobe.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  register word index.
- wdata  in  32  write data; bits above IO_W ignored.
- rdata  out  32  read data; zero-extended from IO_W.
- ready  out  1  access-complete pulse.
- io_rdata  in  IO_W  raw asynchronous switch inputs.
- io_wdata  out  IO_W  registered LED outputs.
- irq  out  1  interrupt; present only with MMIO_IO_IRQ_EN, else tied 0.

Behaviour:
- Reset (rst=0, async): all outputs 0; sync FFs, debounce shift registers, accepted switch value, LED, status and mask registers 0; tick counter 0.
- Handshake: req sampled on a rising clk edge; ready=1 for exactly the next cycle with rdata valid, then ready=0 and rdata=0.
- req asserted in the cycle ready is high is accepted as a new access; back-to-back accesses sustain one per cycle.
- Writes take effect at the same edge that raises ready.
- Register map (word index):
  - 0 SW: read-only accepted switch value.
  - 1 LED: read/write; io_wdata = LED register.
  - 2 EDGE: rising-edge status, W1C.
  - 3 MASK: interrupt mask; exists only with the feature, otherwise reads 0.
- Unmapped addresses: read 0, write ignored, ready still pulses.
- Input path: io_rdata passes through 2 FFs into synced.
- Tick counter counts 0..DEB_DIV-1, wraps, and emits tick at DEB_DIV-1.
- Per bit on tick: shift synced bit into a DEB_N-bit history. If the history is all ones or all zeros and differs from the accepted bit, the accepted bit updates on that tick.
- Worst-case latency from a stable input change to the SW update: 2 + DEB_N*DEB_DIV cycles.
- Pulses shorter than (DEB_N-1)*DEB_DIV cycles never update SW.
- EDGE bit sets in the cycle its accepted bit goes 0->1. The accepted-value register updates as EDGE sets, so a read issued in that same cycle returns the old accepted value.
- Simultaneous W1C write and new edge on the same bit: the bit stays 1 (set wins).
- Write of 0 bits leaves EDGE unchanged.
- Reset mid-access: ready is dropped immediately and the access is lost.

Optional Feature:
- Macro MMIO_IO_IRQ_EN.
- Defined: MASK register at index 3 (read/write, reset 0); irq registered, equal to OR of (EDGE & MASK), one cycle after EDGE/MASK change; level stays asserted until cleared.
- Undefined: no MASK storage, index 3 unmapped, irq constant 0.

Decomposition:
- Package mmio_io_pkg: register index constants SW_IDX=0, LED_IDX=1, EDGE_IDX=2, MASK_IDX=3; bus data width constant 32.
- Sub-module io_debounce: parameters IO_W, DEB_DIV, DEB_N; inputs clk, rst, raw; outputs level and rise pulse vector.
- io_debounce holds the synchroniser, tick counter and histories. The top holds the bus decode and registers.

Test Plan (DEB_DIV=4, DEB_N=4, IO_W=24):
1. Reset: rst low 20 cycles with io_rdata=24'hFFFFFF -> io_wdata=0, rdata=0, ready=0, irq=0. After release, SW reads 0 until 2+16 cycles have elapsed, then reads 0x00FFFFFF and EDGE reads 0x00FFFFFF.
2. LED path: write 0xA5A5A5 to index 1 -> ready pulses 1 cycle later, io_wdata=24'hA5A5A5 the same edge, read index 1 returns 0x00A5A5A5. Back-to-back write then read on consecutive cycles both get ready.
3. Debounce: bit 0 high for 8 cycles then low -> SW bit 0 stays 0, EDGE stays 0. Bit 0 held high 40 cycles -> SW=0x000001 within 18 cycles, EDGE=0x000001.
4. W1C: EDGE=0x000009, write 0x000001 to index 2 -> EDGE=0x000008. Write 0x000008 in the same cycle bit 3 gets a new rise -> EDGE stays 0x000008.
5. IRQ (macro on): MASK=0x000008, rise bit 3 -> irq=1 one cycle after EDGE sets. W1C bit 3 -> irq=0 next cycle. Macro off: irq stays 0 and index 3 reads 0.
6. Unmapped index 5: read returns 0 with ready. Write 0xFFFFFFFF changes no register. Async rst asserted during a pending access clears ready immediately.
